// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: register addresses, bit fields, ExcCodes, exception
// sequencer state encoding and event classes.
package cp0_exc_ctrl_pkg;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;

    localparam int STATUS_IE_BIT     = 0;
    localparam int STATUS_EXL_BIT    = 1;
    localparam int STATUS_IM_LSB     = 8;
    localparam int STATUS_BEV_BIT    = 22;
    localparam int CAUSE_EXCODE_LSB  = 2;
    localparam int CAUSE_IP_LSB      = 8;
    localparam int CAUSE_BD_BIT      = 31;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_REDIRECT
    } exc_state_e;

    typedef enum logic [1:0] {
        EVT_NONE,
        EVT_INT,
        EVT_EXC,
        EVT_ERET
    } exc_evt_e;

    // Only address errors carry a meaningful faulting address.
    function automatic logic excode_has_badvaddr(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_int_detect.sv
// Interrupt masking and event priority selection at the commit point.
// Purely combinational; interrupt > synchronous exception > ERET.
module cp0_int_detect
    import cp0_exc_ctrl_pkg::*;
(
    input  logic       commit_valid,
    input  logic       commit_exc,
    input  logic [4:0] commit_excode,
    input  logic       commit_eret,
    input  logic       status_ie,
    input  logic       status_exl,
    input  logic [7:0] status_im,
    input  logic [7:0] cause_ip,
    output exc_evt_e   evt_kind,
    output logic [4:0] evt_excode
);

    logic int_pending;

    always_comb begin
        int_pending = status_ie & ~status_exl & (|(status_im & cause_ip));
        evt_kind    = EVT_NONE;
        evt_excode  = EXC_INT;
        if (commit_valid) begin
            if (int_pending) begin
                evt_kind = EVT_INT;
            end else if (commit_exc) begin
                evt_kind   = EVT_EXC;
                evt_excode = commit_excode;
            end else if (commit_eret) begin
                evt_kind = EVT_ERET;
            end
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/ERET sequencer: accepts one event at the commit point, pulses
// the CP0 register writes, flushes, waits for drain, then redirects fetch.
//
// state       | meaning
// ST_IDLE     | commit point open, waiting for an interrupt/exception/ERET
// ST_DRAIN    | event taken, flush held, waiting for pipe_empty
// ST_REDIRECT | redirect_valid held with the target PC until redirect_ready
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic [31:0] commit_pc,
    input  logic        commit_bd,
    input  logic        commit_exc,
    input  logic [4:0]  commit_excode,
    input  logic [31:0] commit_badvaddr,
    input  logic        commit_eret,
    input  logic        status_ie,
    input  logic        status_exl,
    input  logic [7:0]  status_im,
    input  logic [7:0]  cause_ip,
    input  logic [31:0] epc_in,
    output logic        exception,
    output logic        eret_op,
    output logic        epc_we,
    output logic [31:0] epc_data,
    output logic        cause_we,
    output logic [4:0]  cause_excode,
    output logic        cause_bd,
    output logic        badvaddr_we,
    output logic [31:0] badvaddr_data,
    output logic        flush,
    input  logic        pipe_empty,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic [15:0] exc_count
);

    exc_evt_e   evt_kind;
    logic [4:0] evt_excode;

    cp0_int_detect u_int_detect (
        .commit_valid  (commit_valid),
        .commit_exc    (commit_exc),
        .commit_excode (commit_excode),
        .commit_eret   (commit_eret),
        .status_ie     (status_ie),
        .status_exl    (status_exl),
        .status_im     (status_im),
        .cause_ip      (cause_ip),
        .evt_kind      (evt_kind),
        .evt_excode    (evt_excode)
    );

    exc_state_e  state_q, state_d;
    logic        flush_q, flush_d;
    logic        exception_q, exception_d;
    logic        eret_op_q, eret_op_d;
    logic        epc_we_q, epc_we_d;
    logic [31:0] epc_data_q, epc_data_d;
    logic        cause_we_q, cause_we_d;
    logic [4:0]  cause_excode_q, cause_excode_d;
    logic        cause_bd_q, cause_bd_d;
    logic        badvaddr_we_q, badvaddr_we_d;
    logic [31:0] badvaddr_data_q, badvaddr_data_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [15:0] exc_count_q, exc_count_d;

    always_comb begin
        state_d         = state_q;
        flush_d         = flush_q;
        exception_d     = 1'b0;
        eret_op_d       = 1'b0;
        epc_we_d        = 1'b0;
        cause_we_d      = 1'b0;
        badvaddr_we_d   = 1'b0;
        epc_data_d      = epc_data_q;
        cause_excode_d  = cause_excode_q;
        cause_bd_d      = cause_bd_q;
        badvaddr_data_d = badvaddr_data_q;
        redirect_pc_d   = redirect_pc_q;
        exc_count_d     = exc_count_q;

        case (state_q)
            ST_IDLE: begin
                if (evt_kind != EVT_NONE) begin
                    state_d = ST_DRAIN;
                    flush_d = 1'b1;
                    if (evt_kind == EVT_ERET) begin
                        eret_op_d     = 1'b1;
                        redirect_pc_d = epc_in;
                    end else begin
                        exception_d    = 1'b1;
                        cause_we_d     = 1'b1;
                        cause_excode_d = evt_excode;
                        cause_bd_d     = commit_bd;
                        // A nested exception under EXL must keep the original EPC.
                        if (!status_exl) begin
                            epc_we_d   = 1'b1;
                            epc_data_d = commit_bd ? (commit_pc - 32'd4) : commit_pc;
                        end
                        if (excode_has_badvaddr(evt_excode)) begin
                            badvaddr_we_d   = 1'b1;
                            badvaddr_data_d = commit_badvaddr;
                        end
                        exc_count_d   = exc_count_q + 16'd1;
                        redirect_pc_d = EXC_VECTOR;
                    end
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                    flush_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            flush_q         <= 1'b0;
            exception_q     <= 1'b0;
            eret_op_q       <= 1'b0;
            epc_we_q        <= 1'b0;
            epc_data_q      <= 32'd0;
            cause_we_q      <= 1'b0;
            cause_excode_q  <= 5'd0;
            cause_bd_q      <= 1'b0;
            badvaddr_we_q   <= 1'b0;
            badvaddr_data_q <= 32'd0;
            redirect_pc_q   <= 32'd0;
            exc_count_q     <= 16'd0;
        end else begin
            state_q         <= state_d;
            flush_q         <= flush_d;
            exception_q     <= exception_d;
            eret_op_q       <= eret_op_d;
            epc_we_q        <= epc_we_d;
            epc_data_q      <= epc_data_d;
            cause_we_q      <= cause_we_d;
            cause_excode_q  <= cause_excode_d;
            cause_bd_q      <= cause_bd_d;
            badvaddr_we_q   <= badvaddr_we_d;
            badvaddr_data_q <= badvaddr_data_d;
            redirect_pc_q   <= redirect_pc_d;
            exc_count_q     <= exc_count_d;
        end
    end

    assign commit_ready   = (state_q == ST_IDLE);
    assign redirect_valid = (state_q == ST_REDIRECT);
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign exception      = exception_q;
    assign eret_op        = eret_op_q;
    assign epc_we         = epc_we_q;
    assign epc_data       = epc_data_q;
    assign cause_we       = cause_we_q;
    assign cause_excode   = cause_excode_q;
    assign cause_bd       = cause_bd_q;
    assign badvaddr_we    = badvaddr_we_q;
    assign badvaddr_data  = badvaddr_data_q;
    assign exc_count      = exc_count_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: a table of single-event transactions plus
// hand-written sequences for busy-ignore, stalled redirect and reset in REDIRECT.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid, commit_ready;
    logic [31:0] commit_pc;
    logic        commit_bd, commit_exc;
    logic [4:0]  commit_excode;
    logic [31:0] commit_badvaddr;
    logic        commit_eret;
    logic        status_ie, status_exl;
    logic [7:0]  status_im, cause_ip;
    logic [31:0] epc_in;
    logic        exception, eret_op, epc_we;
    logic [31:0] epc_data;
    logic        cause_we;
    logic [4:0]  cause_excode;
    logic        cause_bd, badvaddr_we;
    logic [31:0] badvaddr_data;
    logic        flush, pipe_empty;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic [15:0] exc_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_pc(commit_pc), .commit_bd(commit_bd),
        .commit_exc(commit_exc), .commit_excode(commit_excode),
        .commit_badvaddr(commit_badvaddr), .commit_eret(commit_eret),
        .status_ie(status_ie), .status_exl(status_exl),
        .status_im(status_im), .cause_ip(cause_ip), .epc_in(epc_in),
        .exception(exception), .eret_op(eret_op),
        .epc_we(epc_we), .epc_data(epc_data),
        .cause_we(cause_we), .cause_excode(cause_excode), .cause_bd(cause_bd),
        .badvaddr_we(badvaddr_we), .badvaddr_data(badvaddr_data),
        .flush(flush), .pipe_empty(pipe_empty),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .exc_count(exc_count)
    );

    typedef struct {
        logic        ie, exl;
        logic [7:0]  im, ip;
        logic [31:0] pc;
        logic        bd, exc;
        logic [4:0]  code;
        logic [31:0] bva;
        logic        eret;
        logic [31:0] epc;
        int          drain;
        logic        e_evt, e_exc, e_eret, e_epc_we;
        logic [31:0] e_epc;
        logic        e_cause_we;
        logic [4:0]  e_code;
        logic        e_bd, e_bva_we;
        logic [31:0] e_bva, e_rpc;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, ".pulses"}, {27'd0, exception, eret_op, epc_we, cause_we, badvaddr_we}, 32'd0);
    endtask

    task automatic idle_inputs();
        commit_valid = 1'b0; commit_exc = 1'b0; commit_eret = 1'b0;
        commit_bd = 1'b0; commit_excode = 5'd0; commit_pc = 32'd0; commit_badvaddr = 32'd0;
        status_ie = 1'b0; status_exl = 1'b0; status_im = 8'd0; cause_ip = 8'd0;
    endtask

    // Called #1 after a posedge with the DUT in IDLE.
    task automatic run_vec(input int idx, input vec_t v);
        string n;
        n = $sformatf("v%0d", idx);
        status_ie = v.ie; status_exl = v.exl; status_im = v.im; cause_ip = v.ip;
        commit_pc = v.pc; commit_bd = v.bd; commit_exc = v.exc; commit_excode = v.code;
        commit_badvaddr = v.bva; commit_eret = v.eret; epc_in = v.epc;
        commit_valid = 1'b1; pipe_empty = 1'b0; redirect_ready = 1'b0;
        @(posedge clk); #1;
        idle_inputs();
        epc_in = 32'hDEAD_BEEF;
        if (v.e_exc) exp_cnt = exp_cnt + 16'd1;
        chk({n, ".exc_count"}, {16'd0, exc_count}, {16'd0, exp_cnt});
        if (!v.e_evt) begin
            chk_quiet(n);
            chk({n, ".flush/ready"}, {30'd0, flush, commit_ready}, 32'd1);
            return;
        end
        chk({n, ".exception"}, {31'd0, exception}, {31'd0, v.e_exc});
        chk({n, ".eret_op"}, {31'd0, eret_op}, {31'd0, v.e_eret});
        chk({n, ".epc_we"}, {31'd0, epc_we}, {31'd0, v.e_epc_we});
        if (v.e_epc_we) chk({n, ".epc_data"}, epc_data, v.e_epc);
        chk({n, ".cause_we"}, {31'd0, cause_we}, {31'd0, v.e_cause_we});
        if (v.e_cause_we) chk({n, ".cause"}, {26'd0, cause_bd, cause_excode}, {26'd0, v.e_bd, v.e_code});
        chk({n, ".badvaddr_we"}, {31'd0, badvaddr_we}, {31'd0, v.e_bva_we});
        if (v.e_bva_we) chk({n, ".badvaddr_data"}, badvaddr_data, v.e_bva);
        chk({n, ".flush/ready"}, {30'd0, flush, commit_ready}, 32'd2);
        for (int i = 0; i < v.drain; i++) begin
            @(posedge clk); #1;
            chk_quiet({n, ".drain"});
            chk({n, ".drain.flush/rv"}, {30'd0, flush, redirect_valid}, 32'd2);
        end
        pipe_empty = 1'b1;
        @(posedge clk); #1;
        pipe_empty = 1'b0;
        chk_quiet({n, ".redir"});
        chk({n, ".redir.flush/rv"}, {30'd0, flush, redirect_valid}, 32'd3);
        chk({n, ".redirect_pc"}, redirect_pc, v.e_rpc);
        redirect_ready = 1'b1;
        @(posedge clk); #1;
        redirect_ready = 1'b0;
        chk({n, ".post.flush/rv/ready"}, {29'd0, flush, redirect_valid, commit_ready}, 32'd1);
    endtask

    initial begin
        // ie exl im ip pc bd exc code bva eret epc drain | evt exc eret epcwe epc cwe code bd bvawe bva rpc
        vecs[0] = '{1'b1, 1'b0, 8'h80, 8'h80, 32'h8000_0100, 1'b0, 1'b0, 5'h00, 32'h0, 1'b0, 32'h0, 0,
                    1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0100, 1'b1, 5'h00, 1'b0, 1'b0, 32'h0, 32'hBFC0_0380};
        vecs[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 32'h8000_0204, 1'b1, 1'b1, 5'h04, 32'h1235, 1'b0, 32'h0, 2,
                    1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0200, 1'b1, 5'h04, 1'b1, 1'b1, 32'h1235, 32'hBFC0_0380};
        vecs[2] = '{1'b1, 1'b0, 8'h80, 8'h40, 32'h8000_0300, 1'b0, 1'b0, 5'h00, 32'h0, 1'b0, 32'h0, 0,
                    1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'h00, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 8'hFF, 8'hFF, 32'h8000_0400, 1'b0, 1'b1, 5'h0C, 32'h0, 1'b1, 32'h8000_0040, 1,
                    1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 5'h0C, 1'b0, 1'b0, 32'h0, 32'hBFC0_0380};
        vecs[4] = '{1'b1, 1'b0, 8'h01, 8'h01, 32'h8000_0500, 1'b1, 1'b1, 5'h05, 32'hDEAD, 1'b0, 32'h0, 0,
                    1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_04FC, 1'b1, 5'h00, 1'b1, 1'b0, 32'h0, 32'hBFC0_0380};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 8'h00, 32'h8000_1000, 1'b0, 1'b1, 5'h05, 32'h0ABC, 1'b0, 32'h0, 3,
                    1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_1000, 1'b1, 5'h05, 1'b0, 1'b1, 32'h0ABC, 32'hBFC0_0380};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h00, 32'h8000_0600, 1'b0, 1'b0, 5'h00, 32'h0, 1'b1, 32'h8000_0040, 5,
                    1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 5'h00, 1'b0, 1'b0, 32'h0, 32'h8000_0040};
        vecs[7] = '{1'b1, 1'b0, 8'h02, 8'h00, 32'h8000_0010, 1'b1, 1'b1, 5'h08, 32'h0, 1'b0, 32'h0, 0,
                    1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_000C, 1'b1, 5'h08, 1'b1, 1'b0, 32'h0, 32'hBFC0_0380};
        vecs[8] = '{1'b1, 1'b0, 8'h04, 8'h04, 32'h8000_0700, 1'b0, 1'b0, 5'h00, 32'h0, 1'b1, 32'h8000_0999, 0,
                    1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0700, 1'b1, 5'h00, 1'b0, 1'b0, 32'h0, 32'hBFC0_0380};

        rst = 1'b1;
        idle_inputs();
        epc_in = 32'd0; pipe_empty = 1'b0; redirect_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk_quiet("reset");
        chk("reset.flush/rv/ready", {29'd0, flush, redirect_valid, commit_ready}, 32'd1);
        chk("reset.exc_count", {16'd0, exc_count}, 32'd0);

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // Events presented while busy are ignored; redirect held while stalled.
        commit_valid = 1'b1; commit_exc = 1'b1; commit_excode = 5'h0A; commit_pc = 32'h8000_0800;
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 16'd1;
        chk("busy.exception", {31'd0, exception}, 32'd1);
        commit_excode = 5'h09;
        repeat (2) begin
            @(posedge clk); #1;
            chk_quiet("busy.drain");
            chk("busy.ready", {31'd0, commit_ready}, 32'd0);
            chk("busy.exc_count", {16'd0, exc_count}, {16'd0, exp_cnt});
        end
        commit_valid = 1'b0; commit_exc = 1'b0; pipe_empty = 1'b1;
        @(posedge clk); #1;
        pipe_empty = 1'b0;
        repeat (3) begin
            chk("stall.rv/flush", {30'd0, redirect_valid, flush}, 32'd3);
            chk("stall.redirect_pc", redirect_pc, 32'hBFC0_0380);
            @(posedge clk); #1;
        end
        redirect_ready = 1'b1;
        @(posedge clk); #1;
        redirect_ready = 1'b0;
        chk("stall.post.flush/rv/ready", {29'd0, flush, redirect_valid, commit_ready}, 32'd1);
        @(posedge clk); #1;
        chk_quiet("stall.idle");
        chk("stall.idle.exc_count", {16'd0, exc_count}, {16'd0, exp_cnt});

        // Reset while stalled in REDIRECT abandons the redirect.
        commit_valid = 1'b1; status_ie = 1'b1; status_im = 8'h10; cause_ip = 8'h10;
        commit_pc = 32'h8000_0A00; pipe_empty = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        pipe_empty = 1'b0;
        chk("rstredir.rv", {31'd0, redirect_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 16'd0;
        chk_quiet("rstredir");
        chk("rstredir.flush/rv/ready", {29'd0, flush, redirect_valid, commit_ready}, 32'd1);
        chk("rstredir.exc_count", {16'd0, exc_count}, 32'd0);

        run_vec(100, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cp0_exc_ctrl.md
CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 Parameter: EXC_VECTOR, default 32'hBFC0_0380, exception entry PC; Status.Bev is hard-wired to 1.
REQ-002 Port: clk  in  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: commit_valid  in  1  one instruction is presented at the commit point.
REQ-005 Port: commit_ready  out  1  commit point accepted; high only in IDLE.
REQ-006 Port: commit_pc  in  32  PC of the committing instruction.
REQ-007 Port: commit_bd  in  1  committing instruction sits in a delay slot.
REQ-008 Port: commit_exc  in  1  synchronous exception flagged on the instruction.
REQ-009 Port: commit_excode  in  5  ExcCode for commit_exc.
REQ-010 Port: commit_badvaddr  in  32  faulting address, valid for ExcCode 0x04 (AdEL) and 0x05 (AdES).
REQ-011 Port: commit_eret  in  1  instruction is ERET.
REQ-012 Ports: status_ie, status_exl  in  1 each; status_im  in  8; cause_ip  in  8  live CP0 fields.
REQ-013 Port: epc_in  in  32  current EPC, used as the ERET target.
REQ-014 Ports: exception, eret_op  out  1 each  one-cycle pulses to the Status/Cause/EPC registers.
REQ-015 Ports: epc_we out 1, epc_data out 32; cause_we out 1, cause_excode out 5, cause_bd out 1; badvaddr_we out 1, badvaddr_data out 32.
REQ-016 Port: flush  out  1  kill all younger pipeline stages.
REQ-017 Port: pipe_empty  in  1  pipeline drain acknowledge.
REQ-018 Ports: redirect_valid out 1, redirect_pc out 32, redirect_ready in 1  fetch redirect handshake.
REQ-019 Port: exc_count  out  16  count of exceptions taken, including interrupts; wraps modulo 2^16.

Function
REQ-020 int_pending SHALL equal status_ie & ~status_exl & |(status_im & cause_ip), evaluated combinationally in the accept cycle.
REQ-021 The FSM SHALL have states IDLE, DRAIN and REDIRECT.
REQ-022 In IDLE, an event SHALL be accepted in cycle T when commit_valid=1 and at least one of int_pending, commit_exc or commit_eret is set.
REQ-023 Event priority SHALL be interrupt (ExcCode 0x00) > commit_exc > commit_eret.
REQ-024 A commit_valid cycle with no event SHALL pass through with no outputs asserted.
REQ-025 At T+1 for an exception or interrupt: exception=1; cause_we=1 with cause_excode and cause_bd=commit_bd; epc_we=1 only if status_exl was 0 at T, with epc_data = commit_bd ? commit_pc-4 : commit_pc; badvaddr_we=1 only for ExcCode 0x04/0x05; exc_count increments.
REQ-026 At T+1 for ERET: eret_op=1 and no cause, EPC or BadVAddr writes.
REQ-027 Every event output pulse SHALL last exactly one cycle.
REQ-028 flush SHALL assert from T+1 through the cycle of the redirect handshake and deassert the following cycle.
REQ-029 After accept the FSM SHALL enter DRAIN, leave it on the first cycle pipe_empty=1 (no minimum dwell), and enter REDIRECT.
REQ-030 In REDIRECT, redirect_valid SHALL be 1 with redirect_pc = EXC_VECTOR, or epc_in captured at accept for ERET, held stable until redirect_ready=1, then return to IDLE.
REQ-031 commit_ready SHALL be 0 outside IDLE; events presented there are ignored until IDLE is re-entered.
REQ-032 An exception taken while EXL=1 SHALL still update Cause and redirect, but SHALL NOT write EPC.

Reset
REQ-033 rst SHALL return the FSM to IDLE from any state, abandoning any in-flight redirect.
REQ-034 rst SHALL clear flush, redirect_valid, all pulses and all write enables to 0, and set exc_count to 0.
REQ-035 Outputs SHALL be valid in the cycle after rst deasserts.

Structure
REQ-036 ExcCode constants, FSM state encoding and the EXC_VECTOR default SHALL live in the shared CP0 defines header alongside the CP0 address and bit-field constants.
REQ-037 Interrupt masking and priority selection SHALL be one combinational sub-module, cp0_int_detect; all other logic is registered in cp0_exc_ctrl.

Verification
REQ-038 IE=1, EXL=0, IM=8'h80, IP=8'h80, commit_pc=0x8000_0100 -> T+1: exception=1, excode=0, epc_data=0x8000_0100; redirect_pc=0xBFC0_0380.
REQ-039 commit_exc with excode=0x04, bd=1, pc=0x8000_0204, badvaddr=0x1235 -> epc_data=0x8000_0200, cause_bd=1, badvaddr_we=1 with 0x1235.
REQ-040 commit_eret with epc_in=0x8000_0040 and pipe_empty held low 5 cycles -> eret_op pulse, flush high throughout, redirect_pc=0x8000_0040 after drain.
REQ-041 commit_exc and commit_eret together with EXL=1 -> exception path taken, epc_we=0, cause_we=1.
REQ-042 rst asserted in REDIRECT with redirect_ready=0 -> next cycle IDLE, flush=0, redirect_valid=0, exc_count=0.
